// File: rtl/t01_ai_mac_engine_if.sv
// Activation-in / result-out handshake bundle for the AI evaluator MAC engine.
// master drives activations and consumes results; slave is the engine.
interface t01_ai_mac_engine_if #(
  parameter int ACT_W   = 8,
  parameter int ACC_W   = 18,
  parameter int MAX_OUT = 32
);
  localparam int IDX_W = $clog2(MAX_OUT);

  logic                    act_valid;
  logic                    act_ready;
  logic signed [ACT_W-1:0] act_in;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [ACC_W-1:0] res_out;
  logic [IDX_W-1:0]        res_idx;

  modport master (
    output act_valid, act_in, res_ready,
    input  act_ready, res_valid, res_out, res_idx
  );

  modport slave (
    input  act_valid, act_in, res_ready,
    output act_ready, res_valid, res_out, res_idx
  );
endinterface

// File: rtl/t01_ai_mac_engine.sv
// Dense-layer matrix-vector MAC engine: run-time loaded weights/biases, saturating
// accumulation over streamed activations, then biased/shifted/ReLU results streamed out.
module t01_ai_mac_engine #(
  parameter int ACT_W   = 8,
  parameter int WGT_W   = 4,
  parameter int ACC_W   = 18,
  parameter int MAX_IN  = 32,
  parameter int MAX_OUT = 32,
  localparam int NI_W   = $clog2(MAX_IN + 1),
  localparam int NO_W   = $clog2(MAX_OUT + 1),
  localparam int WA_W   = $clog2(MAX_IN * MAX_OUT),
  localparam int IDX_W  = $clog2(MAX_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NI_W-1:0]         cfg_n_in,
  input  logic [NO_W-1:0]         cfg_n_out,
  input  logic [3:0]              cfg_shift,
  input  logic                    cfg_relu,
  input  logic                    w_wr_en,
  input  logic [WA_W-1:0]         w_wr_addr,
  input  logic signed [WGT_W-1:0] w_wr_data,
  input  logic                    b_wr_en,
  input  logic [IDX_W-1:0]        b_wr_addr,
  input  logic signed [WGT_W-1:0] b_wr_data,
  t01_ai_mac_engine_if.slave      mac_if,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [NI_W-1:0]         n_in_q, k_q;
  logic [NO_W-1:0]         n_out_q, rd_q;
  logic [3:0]              shift_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] acc_q [MAX_OUT];
  logic signed [WGT_W-1:0] wmem  [MAX_IN*MAX_OUT];
  logic signed [WGT_W-1:0] bmem  [MAX_OUT];
  logic signed [ACT_W+WGT_W-1:0] prod [MAX_OUT];
  logic [WA_W-1:0]         widx;
  logic                    vld_p1;
  logic signed [ACC_W-1:0] res_p1;
  logic [IDX_W-1:0]        idx_p1;
  logic                    act_hs, last_act, issue, res_hs, last_res, start_ok;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [WGT_W-1:0] b,
                                                        input logic [3:0] sh,
                                                        input logic relu);
    logic signed [ACC_W-1:0] t;
    t = sat_add(a, ACC_W'(b));
    t = t >>> sh;
    if (relu && t[ACC_W-1]) t = '0;
    return t;
  endfunction

  function automatic logic [NI_W-1:0] clamp_in(input logic [NI_W-1:0] v);
    if (v == '0) return NI_W'(1);
    if (v > NI_W'(MAX_IN)) return NI_W'(MAX_IN);
    return v;
  endfunction

  function automatic logic [NO_W-1:0] clamp_out(input logic [NO_W-1:0] v);
    if (v == '0) return NO_W'(1);
    if (v > NO_W'(MAX_OUT)) return NO_W'(MAX_OUT);
    return v;
  endfunction

  assign mac_if.act_ready = (state_q == MAC);
  assign busy             = (state_q != IDLE);
  assign start_ok         = (state_q == IDLE) && start;
  assign act_hs           = mac_if.act_valid && mac_if.act_ready;
  assign last_act         = act_hs && (k_q == n_in_q - NI_W'(1));
  assign res_hs           = vld_p1 && mac_if.res_ready;
  assign last_res         = res_hs && (NO_W'(idx_p1) == n_out_q - NO_W'(1));
  assign issue            = (state_q == DRAIN) && (rd_q != n_out_q) && (!vld_p1 || mac_if.res_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = MAC;
      MAC:     if (last_act) state_d = DRAIN;
      DRAIN:   if (last_res) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_in_q  <= '0;
      n_out_q <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      k_q     <= '0;
      rd_q    <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= last_res;
      if (start_ok) begin
        n_in_q  <= clamp_in(cfg_n_in);
        n_out_q <= clamp_out(cfg_n_out);
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
        k_q     <= '0;
        rd_q    <= '0;
      end
      if (act_hs) k_q  <= k_q + NI_W'(1);
      if (issue)  rd_q <= rd_q + NO_W'(1);
    end
  end

  // Weight/bias store: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && w_wr_en) wmem[w_wr_addr] <= w_wr_data;
    if (state_q == IDLE && b_wr_en) bmem[b_wr_addr] <= b_wr_data;
  end

  // Stage p0: one product per output row for the current input column k.
  always_comb begin
    widx = '0;
    for (int j = 0; j < MAX_OUT; j++) begin
      widx    = WA_W'(j * MAX_IN) + WA_W'(k_q);
      prod[j] = mac_if.act_in * wmem[widx];
    end
  end

  // Stage p1: accumulator update and registered result output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < MAX_OUT; j++) acc_q[j] <= '0;
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      idx_p1 <= '0;
    end else begin
      if (start_ok) begin
        for (int j = 0; j < MAX_OUT; j++) acc_q[j] <= '0;
      end else if (act_hs) begin
        for (int j = 0; j < MAX_OUT; j++)
          if (NO_W'(j) < n_out_q) acc_q[j] <= sat_add(acc_q[j], ACC_W'(prod[j]));
      end
      if (issue) begin
        vld_p1 <= 1'b1;
        res_p1 <= post_proc(acc_q[rd_q[IDX_W-1:0]], bmem[rd_q[IDX_W-1:0]], shift_q, relu_q);
        idx_p1 <= rd_q[IDX_W-1:0];
      end else if (res_hs) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign mac_if.res_valid = vld_p1;
  assign mac_if.res_out   = res_p1;
  assign mac_if.res_idx   = idx_p1;

endmodule

// File: tb/tb_t01_ai_mac_engine.sv
// Scoreboard bench for t01_ai_mac_engine: an 18-bit and a 12-bit accumulator instance
// run in lockstep on identical stimulus, each checked against an integer layer model.
module tb_t01_ai_mac_engine;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [5:0]        cfg_n_in = '0, cfg_n_out = '0;
  logic [3:0]        cfg_shift = '0;
  logic              cfg_relu = 1'b0;
  logic              w_wr_en = 1'b0;
  logic [9:0]        w_wr_addr = '0;
  logic signed [3:0] w_wr_data = '0;
  logic              b_wr_en = 1'b0;
  logic [4:0]        b_wr_addr = '0;
  logic signed [3:0] b_wr_data = '0;
  logic              act_valid = 1'b0;
  logic signed [7:0] act_in = '0;
  logic              res_ready = 1'b0;
  logic              busy0, done0, busy1, done1;

  t01_ai_mac_engine_if #(.ACT_W(8), .ACC_W(18), .MAX_OUT(32)) if0 ();
  t01_ai_mac_engine_if #(.ACT_W(8), .ACC_W(12), .MAX_OUT(32)) if1 ();

  assign if0.act_valid = act_valid;
  assign if0.act_in    = act_in;
  assign if0.res_ready = res_ready;
  assign if1.act_valid = act_valid;
  assign if1.act_in    = act_in;
  assign if1.res_ready = res_ready;

  t01_ai_mac_engine #(.ACT_W(8), .WGT_W(4), .ACC_W(18), .MAX_IN(32), .MAX_OUT(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data), .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .mac_if(if0), .busy(busy0), .done(done0));

  t01_ai_mac_engine #(.ACT_W(8), .WGT_W(4), .ACC_W(12), .MAX_IN(32), .MAX_OUT(32)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data), .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .mac_if(if1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  typedef struct { longint val; int idx; } exp_t;
  exp_t   q0[$], q1[$];
  exp_t   e0, e1;
  int     wm [1024];
  int     bm [32];
  int     acts [64];
  bit     rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int     n_vec = 0, n_err = 0;
  int     cur_nout = 1;
  bit     exp_done = 1'b0, stall0 = 1'b0, stall1 = 1'b0;
  longint h0_out, h1_out;
  int     h0_idx, h1_idx;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint msat(input longint v, input int aw);
    longint hi, lo;
    hi = (longint'(1) <<< (aw - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic push_expected(input int ni, input int no, input int sh, input int rl);
    longint acc, t;
    int aw;
    exp_t e;
    for (int j = 0; j < no; j++) begin
      for (int w = 0; w < 2; w++) begin
        aw = (w == 0) ? 18 : 12;
        acc = 0;
        for (int k = 0; k < ni; k++)
          acc = msat(acc + longint'(acts[k] * wm[j*32 + k]), aw);
        t = msat(acc + longint'(bm[j]), aw);
        t = t >>> sh;
        if (rl != 0 && t < 0) t = 0;
        e.val = t;
        e.idx = j;
        if (w == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all();
    w_wr_en = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      w_wr_addr = 10'(a);
      w_wr_data = 4'(wm[a]);
      tick();
    end
    w_wr_en = 1'b0;
    b_wr_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      b_wr_addr = 5'(a);
      b_wr_data = 4'(bm[a]);
      tick();
    end
    b_wr_en = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_act_ready"}, if0.act_ready, 0);
    check({tag, "_res_valid"}, if0.res_valid, 0);
    check({tag, "_res_out"}, if0.res_out, 0);
    check({tag, "_res_idx"}, if0.res_idx, 0);
    check({tag, "_res_valid_sat"}, if1.res_valid, 0);
    check({tag, "_busy_sat"}, busy1, 0);
  endtask

  task automatic run(input int ni, input int no, input int sh, input int rl, input int offer,
                     input bit gap, input bit stall, input int abort_at, input bit wr_mid);
    int eni, eno, acc_cnt, i, cyc, last_cyc, rc;
    bit aborted;
    eni = (ni == 0) ? 1 : (ni > 32) ? 32 : ni;
    eno = (no == 0) ? 1 : (no > 32) ? 32 : no;
    push_expected(eni, eno, sh, rl);
    cur_nout  = eno;
    cfg_n_in  = 6'(ni);
    cfg_n_out = 6'(no);
    cfg_shift = 4'(sh);
    cfg_relu  = rl[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    acc_cnt = 0; i = 0; last_cyc = -1;
    for (cyc = 0; cyc < 400; cyc++) begin
      act_valid = (i < offer) && !(gap && (cyc % 3 == 2));
      act_in    = 8'(acts[(i < 64) ? i : 0]);
      w_wr_en   = wr_mid && (cyc == 1);
      w_wr_addr = '0;
      w_wr_data = 4'sd7;
      b_wr_en   = wr_mid && (cyc == 1);
      b_wr_addr = '0;
      b_wr_data = 4'sd7;
      @(negedge clk);
      if (cyc == 0) begin
        check("busy_after_start", busy0, 1);
        check("act_ready_after_start", if0.act_ready, 1);
      end
      if (act_valid && if0.act_ready) begin
        acc_cnt++; i++; last_cyc = cyc;
      end else if (acc_cnt > 0 && !if0.act_ready) begin
        break;
      end
      tick();
    end
    act_valid = 1'b0; w_wr_en = 1'b0; b_wr_en = 1'b0;
    check("acts_accepted", acc_cnt, eni);
    check("act_ready_drop_cycle", cyc, last_cyc + 1);
    check("res_valid_before_first", if0.res_valid, 0);
    aborted = 1'b0;
    for (rc = 0; rc < 2000; rc++) begin
      tick();
      res_ready = stall ? rdy_pat[rc % 4] : 1'b1;
      @(negedge clk);
      if (rc == 0) begin
        check("first_res_valid", if0.res_valid, 1);
        check("first_res_idx", if0.res_idx, 0);
        check("first_res_valid_sat", if1.res_valid, 1);
      end
      if (abort_at >= 0 && if0.res_valid && if0.res_ready && int'(if0.res_idx) == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (done0) break;
    end
    if (aborted) begin
      tick();
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      @(negedge clk);
      check_reset("abort");
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("no_done_after_abort", done0, 0);
      end
    end else begin
      check("done_seen", done0, 1);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
    end
    res_ready = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall0 = 1'b0; stall1 = 1'b0; exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        check("done_pulse", done0, 1);
        check("done_pulse_sat", done1, 1);
        check("idle_after_done", busy0, 0);
        check("valid_after_done", if0.res_valid, 0);
        exp_done = 1'b0;
      end else if (done0 || done1) begin
        check("spurious_done", done0 | done1, 0);
      end
      if (stall0) begin
        check("hold_valid", if0.res_valid, 1);
        check("hold_out", $signed(if0.res_out), h0_out);
        check("hold_idx", if0.res_idx, h0_idx);
      end
      if (stall1) begin
        check("hold_out_sat", $signed(if1.res_out), h1_out);
        check("hold_idx_sat", if1.res_idx, h1_idx);
      end
      if (if0.res_valid && if0.res_ready) begin
        if (q0.size() == 0) check("extra_result", if0.res_idx, -1);
        else begin
          e0 = q0.pop_front();
          check("res", $signed(if0.res_out), e0.val);
          check("res_idx", if0.res_idx, e0.idx);
          if (e0.idx == cur_nout - 1) exp_done = 1'b1;
        end
      end
      if (if1.res_valid && if1.res_ready) begin
        if (q1.size() == 0) check("extra_result_sat", if1.res_idx, -1);
        else begin
          e1 = q1.pop_front();
          check("res_sat", $signed(if1.res_out), e1.val);
          check("res_idx_sat", if1.res_idx, e1.idx);
        end
      end
      stall0 = if0.res_valid && !if0.res_ready;
      h0_out = $signed(if0.res_out);
      h0_idx = int'(if0.res_idx);
      stall1 = if1.res_valid && !if1.res_ready;
      h1_out = $signed(if1.res_out);
      h1_idx = int'(if1.res_idx);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // basic layer: row0 all +1, row1 all -1
    for (int a = 0; a < 1024; a++) wm[a] = 0;
    for (int a = 0; a < 32; a++) bm[a] = 0;
    for (int k = 0; k < 4; k++) begin wm[k] = 1; wm[32 + k] = -1; end
    load_all();
    for (int k = 0; k < 64; k++) acts[k] = 0;
    for (int k = 0; k < 4; k++) acts[k] = k + 1;
    run(4, 2, 0, 0, 4, 1'b0, 1'b0, -1, 1'b0);

    // bias written one cycle before start, then ReLU and shift
    b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 4'sd3; bm[0] = 3;
    tick();
    b_wr_en = 1'b0;
    run(4, 2, 1, 1, 4, 1'b0, 1'b0, -1, 1'b0);

    // full 32x32 random layer, free-running then stalled/gapped
    for (int a = 0; a < 1024; a++) wm[a] = int'($urandom_range(0, 15)) - 8;
    for (int a = 0; a < 32; a++) bm[a] = int'($urandom_range(0, 15)) - 8;
    for (int k = 0; k < 64; k++) acts[k] = int'($urandom_range(0, 255)) - 128;
    load_all();
    run(32, 32, 3, 0, 32, 1'b0, 1'b0, -1, 1'b0);
    run(32, 32, 3, 0, 32, 1'b1, 1'b1, -1, 1'b0);

    // abort during drain, then rerun against the same golden results
    run(32, 32, 3, 0, 32, 1'b0, 1'b0, 5, 1'b0);
    run(32, 32, 3, 0, 32, 1'b0, 1'b0, -1, 1'b0);

    // saturation: all weights -8
    for (int a = 0; a < 1024; a++) wm[a] = -8;
    for (int a = 0; a < 32; a++) bm[a] = 0;
    load_all();
    for (int k = 0; k < 64; k++) acts[k] = -128;
    run(4, 2, 0, 0, 4, 1'b0, 1'b0, -1, 1'b0);
    for (int k = 0; k < 64; k++) acts[k] = 127;
    run(4, 2, 0, 0, 4, 1'b0, 1'b0, -1, 1'b0);
    run(2, 2, 0, 0, 2, 1'b0, 1'b0, -1, 1'b0);

    // writes while busy are dropped; then clamped shape with extra activations offered
    run(4, 2, 0, 0, 4, 1'b0, 1'b0, -1, 1'b1);
    run(0, 40, 0, 0, 3, 1'b0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
